// File: rtl/ex_muldiv_unit_if.sv
// Issue/result bus between EX-stage decode and the HI/LO multiply-divide unit.
interface ex_muldiv_unit_if;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, Op, A, B, input Busy, HI, LO);
  modport slave  (input Start, Op, A, B, output Busy, HI, LO);
endinterface

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: fixed-latency mult/multu/div/divu and
// single-cycle mthi/mtlo into HI/LO, with Busy for the hazard unit.
module ex_muldiv_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic            Clk,
  input  logic            Reset,
  ex_muldiv_unit_if.slave bus
);

  localparam int unsigned CountW = 4;
  localparam int unsigned DataW  = 32;

  typedef enum logic {Idle, Run} stateT;

  stateT               state;
  logic [CountW-1:0]   count;
  logic [DataW-1:0]    opA;
  logic [DataW-1:0]    opB;
  logic [1:0]          opSel;
  logic                busyQ;
  logic [DataW-1:0]    hiQ;
  logic [DataW-1:0]    loQ;

  logic [2*DataW-1:0]  prodS;
  logic [2*DataW-1:0]  prodU;
  logic [DataW-1:0]    magA;
  logic [DataW-1:0]    magB;
  logic [DataW-1:0]    quotM;
  logic [DataW-1:0]    remM;
  logic [DataW-1:0]    quotS;
  logic [DataW-1:0]    remS;
  logic [DataW-1:0]    quotU;
  logic [DataW-1:0]    remU;
  logic [2*DataW-1:0]  result;

  // Result from the latched operands; captured into HI/LO on the final busy cycle.
  always_comb begin
    prodS  = 64'($signed(opA)) * 64'($signed(opB));
    prodU  = 64'(opA) * 64'(opB);
    magA   = opA[DataW-1] ? 32'(-opA) : opA;
    magB   = opB[DataW-1] ? 32'(-opB) : opB;
    quotM  = '0;
    remM   = '0;
    quotU  = '0;
    remU   = '0;
    if (opB != '0) begin
      quotM = magA / magB;
      remM  = magA % magB;
      quotU = opA / opB;
      remU  = opA % opB;
    end
    // Magnitude division keeps 0x80000000 / -1 well defined: quotient 0x80000000, remainder 0.
    quotS  = (opA[DataW-1] ^ opB[DataW-1]) ? 32'(-quotM) : quotM;
    remS   = opA[DataW-1] ? 32'(-remM) : remM;
    result = '0;
    case (opSel)
      2'd0:    result = prodS;
      2'd1:    result = prodU;
      2'd2:    result = {remS, quotS};
      default: result = {remU, quotU};
    endcase
    if (opSel[1] && opB == '0) begin
      result = {opA, 32'hFFFF_FFFF};
    end
  end

  // Control FSM; reset wins over Start and drops any in-flight op.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= Idle;
      count <= '0;
      opA   <= '0;
      opB   <= '0;
      opSel <= '0;
      busyQ <= 1'b0;
      hiQ   <= '0;
      loQ   <= '0;
    end else begin
      case (state)
        Idle: begin
          if (bus.Start) begin
            case (bus.Op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                opA   <= bus.A;
                opB   <= bus.B;
                opSel <= bus.Op[1:0];
                count <= bus.Op[1] ? CountW'(DIV_CYCLES) : CountW'(MULT_CYCLES);
                busyQ <= 1'b1;
                state <= Run;
              end
              3'd4:    hiQ <= bus.A;
              3'd5:    loQ <= bus.A;
              default: ;
            endcase
          end
        end
        Run: begin
          if (count == CountW'(1)) begin
            {hiQ, loQ} <= result;
            count      <= '0;
            busyQ      <= 1'b0;
            state      <= Idle;
          end else begin
            count <= count - CountW'(1);
          end
        end
      endcase
    end
  end

  assign bus.Busy = busyQ;
  assign bus.HI   = hiQ;
  assign bus.LO   = loQ;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized self-checking bench for ex_muldiv_unit against an arithmetic reference model.
module tb_ex_muldiv_unit;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] refHiLo;

  ex_muldiv_unit_if bus ();

  ex_muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural result of one instruction given the current {HI,LO}.
  function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sb); return p; end
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd4: return {a, cur[31:0]};
      3'd5: return {cur[63:32], a};
      default: return cur;
    endcase
  endfunction

  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit inject);
    logic [63:0] prev, expv;
    int n, cnt;
    prev = refHiLo;
    expv = refResult(op, a, b, refHiLo);
    bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    @(posedge Clk); #1;
    bus.Start = 1'b0; bus.Op = 3'($urandom); bus.A = $urandom; bus.B = $urandom;
    if (op < 3'd4) begin
      n = (op < 3'd2) ? 5 : 10;
      cnt = 0;
      checkEq($sformatf("op%0d staleHiLo", op), {bus.HI, bus.LO}, prev);
      while (bus.Busy && cnt < 40) begin
        cnt++;
        bus.Start = inject && (cnt == 2);
        bus.Op = 3'd0; bus.A = $urandom; bus.B = $urandom;
        @(posedge Clk); #1;
      end
      bus.Start = 1'b0;
      checkEq($sformatf("op%0d busyCycles", op), 64'(cnt), 64'(n));
    end else begin
      checkEq($sformatf("op%0d busySingle", op), 64'(bus.Busy), 64'd0);
    end
    checkEq($sformatf("op%0d a=%h b=%h hilo", op, a, b), {bus.HI, bus.LO}, expv);
    refHiLo = expv;
  endtask

  initial begin
    bus.Start = 1'b0; bus.Op = 3'd0; bus.A = '0; bus.B = '0;
    Reset = 1'b0;
    refHiLo = '0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    checkEq("reset busy", 64'(bus.Busy), 64'd0);
    checkEq("reset hilo", {bus.HI, bus.LO}, 64'd0);

    runOp(3'd6, 32'h1111_2222, 32'h3, 1'b0);
    runOp(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
    checkEq("mult -2*3", refHiLo, 64'hFFFF_FFFF_FFFF_FFFA);
    runOp(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    checkEq("multu", refHiLo, 64'h0000_0002_FFFF_FFFA);
    runOp(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    checkEq("div -7/2", refHiLo, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp(3'd3, 32'd7, 32'd0, 1'b0);
    checkEq("divu by 0", refHiLo, 64'h0000_0007_FFFF_FFFF);
    runOp(3'd5, 32'h1234, 32'd0, 1'b0);
    runOp(3'd4, 32'hCAFE_F00D, 32'd0, 1'b0);
    runOp(3'd0, 32'h0001_0003, 32'h7FFF_0001, 1'b1);
    runOp(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    checkEq("div overflow", refHiLo, 64'h0000_0000_8000_0000);
    runOp(3'd2, 32'h8000_0000, 32'd0, 1'b0);

    // Abandon an in-flight div with reset on its 4th busy cycle.
    bus.Start = 1'b1; bus.Op = 3'd2; bus.A = 32'd100; bus.B = 32'd7;
    @(posedge Clk); #1 bus.Start = 1'b0;
    repeat (3) begin @(posedge Clk); #1; end
    checkEq("busy before reset", 64'(bus.Busy), 64'd1);
    Reset = 1'b0;
    @(posedge Clk); #1 Reset = 1'b1;
    refHiLo = '0;
    checkEq("midop reset busy", 64'(bus.Busy), 64'd0);
    checkEq("midop reset hilo", {bus.HI, bus.LO}, 64'd0);
    runOp(3'd3, 32'd100, 32'd7, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 9));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      runOp(op, a, b, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
